// File: rtl/wallclock_core_param.sv
// Wall-clock core: BCD hh:mm:ss counter with tick prescaler, fast mode,
// runtime 12h/24h display, lossless manual set and an armed minute alarm.
module wallclock_core_param #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int FAST_DIV      = 1000,
   parameter int CNT_W         = 27
) (
   input  logic       CLK100MHZ,
   input  logic       RESET_BTN_N,
   input  logic       MODE_12H,
   input  logic       FAST,
   input  logic       INC_MIN,
   input  logic       INC_HOUR,
   input  logic       ALARM_SET,
   input  logic       ALARM_ARM,
   input  logic       ALARM_ACK,
   output logic       SEC_TICK,
   output logic [3:0] HOURS_T,
   output logic [3:0] HOURS_U,
   output logic [3:0] MINS_T,
   output logic [3:0] MINS_U,
   output logic [3:0] SECS_T,
   output logic [3:0] SECS_U,
   output logic       PM,
   output logic       ALARM
);
   localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(TICKS_PER_SEC - 1);
   localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(TICKS_PER_SEC / FAST_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_last;
   logic             wrap;
   logic             sec_tick;
   logic [4:0]       hour_r, hour_n, al_hour_r, al_hour_n;
   logic [5:0]       min_r, min_n, sec_r, sec_n, al_min_r, al_min_n;
   logic             pend_min, pend_hour, inc_min_q, inc_hour_q;
   logic             min_edge, hour_edge, match, alarm_r;
   logic [4:0]       src_hour, disp_hour;
   logic [5:0]       src_min;

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   function automatic logic [4:0] to_12h(input logic [4:0] h);
      if (h == 5'd0)      return 5'd12;
      else if (h > 5'd12) return h - 5'd12;
      else                return h;
   endfunction

   // The >= compare lets a FAST change mid-count take effect at once.
   assign cnt_last = FAST ? LAST_FAST : LAST_NORM;
   assign wrap     = (cnt >= cnt_last);

   always_ff @(posedge CLK100MHZ or negedge RESET_BTN_N) begin
      if (!RESET_BTN_N) begin
         cnt      <= '0;
         sec_tick <= 1'b0;
      end else begin
         cnt      <= wrap ? '0 : cnt + CNT_W'(1);
         sec_tick <= wrap;
      end
   end

   assign min_edge  = INC_MIN  & ~inc_min_q;
   assign hour_edge = INC_HOUR & ~inc_hour_q;

   always_comb begin
      hour_n    = hour_r;
      min_n     = min_r;
      sec_n     = sec_r;
      al_hour_n = al_hour_r;
      al_min_n  = al_min_r;
      match     = 1'b0;
      if (sec_tick) begin
         if (sec_r == 6'd59) begin
            sec_n = 6'd0;
            if (min_r == 6'd59) begin
               min_n  = 6'd0;
               hour_n = (hour_r == 5'd23) ? 5'd0 : hour_r + 5'd1;
            end else begin
               min_n = min_r + 6'd1;
            end
         end else begin
            sec_n = sec_r + 6'd1;
         end
         match = (sec_n == 6'd0) && (min_n == al_min_r) && (hour_n == al_hour_r);
      end else begin
         // Manual edits wait for a tick-free cycle; minute edits never carry.
         if (pend_min) begin
            if (ALARM_SET) al_min_n = (al_min_r == 6'd59) ? 6'd0 : al_min_r + 6'd1;
            else           min_n    = (min_r == 6'd59) ? 6'd0 : min_r + 6'd1;
         end
         if (pend_hour) begin
            if (ALARM_SET) al_hour_n = (al_hour_r == 5'd23) ? 5'd0 : al_hour_r + 5'd1;
            else           hour_n    = (hour_r == 5'd23) ? 5'd0 : hour_r + 5'd1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge RESET_BTN_N) begin
      if (!RESET_BTN_N) begin
         inc_min_q  <= 1'b1;
         inc_hour_q <= 1'b1;
         pend_min   <= 1'b0;
         pend_hour  <= 1'b0;
         hour_r     <= 5'd0;
         min_r      <= 6'd0;
         sec_r      <= 6'd0;
         al_hour_r  <= 5'd0;
         al_min_r   <= 6'd0;
         alarm_r    <= 1'b0;
      end else begin
         inc_min_q  <= INC_MIN;
         inc_hour_q <= INC_HOUR;
         pend_min   <= min_edge  | (pend_min  & sec_tick);
         pend_hour  <= hour_edge | (pend_hour & sec_tick);
         hour_r     <= hour_n;
         min_r      <= min_n;
         sec_r      <= sec_n;
         al_hour_r  <= al_hour_n;
         al_min_r   <= al_min_n;
         if (!ALARM_ARM || ALARM_ACK) alarm_r <= 1'b0;
         else if (match)              alarm_r <= 1'b1;
      end
   end

   assign src_hour  = ALARM_SET ? al_hour_r : hour_r;
   assign src_min   = ALARM_SET ? al_min_r  : min_r;
   assign disp_hour = MODE_12H ? to_12h(src_hour) : src_hour;

   assign {HOURS_T, HOURS_U} = to_bcd({1'b0, disp_hour});
   assign {MINS_T, MINS_U}   = to_bcd(src_min);
   assign {SECS_T, SECS_U}   = to_bcd(sec_r);
   assign PM       = (src_hour >= 5'd12);
   assign SEC_TICK = sec_tick;
   assign ALARM    = alarm_r;

endmodule

// File: tb/tb_wallclock_core_param.sv
// Bench for wallclock_core_param: scenario tasks plus randomized run, checked
// against a seconds-of-day reference model.
module tb_wallclock_core_param;
   localparam int TPS = 10;
   localparam int FDV = 2;

   logic       CLK100MHZ = 1'b0;
   logic       RESET_BTN_N = 1'b0;
   logic       MODE_12H = 1'b0, FAST = 1'b0, INC_MIN = 1'b0, INC_HOUR = 1'b0;
   logic       ALARM_SET = 1'b0, ALARM_ARM = 1'b0, ALARM_ACK = 1'b0;
   logic       SEC_TICK, PM, ALARM;
   logic [3:0] HOURS_T, HOURS_U, MINS_T, MINS_U, SECS_T, SECS_U;

   int checks = 0;
   int failures = 0;

   wallclock_core_param #(.TICKS_PER_SEC(TPS), .FAST_DIV(FDV), .CNT_W(27)) dut (
      .CLK100MHZ(CLK100MHZ), .RESET_BTN_N(RESET_BTN_N), .MODE_12H(MODE_12H),
      .FAST(FAST), .INC_MIN(INC_MIN), .INC_HOUR(INC_HOUR), .ALARM_SET(ALARM_SET),
      .ALARM_ARM(ALARM_ARM), .ALARM_ACK(ALARM_ACK), .SEC_TICK(SEC_TICK),
      .HOURS_T(HOURS_T), .HOURS_U(HOURS_U), .MINS_T(MINS_T), .MINS_U(MINS_U),
      .SECS_T(SECS_T), .SECS_U(SECS_U), .PM(PM), .ALARM(ALARM)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   wire [26:0] dut_vec = {SEC_TICK, HOURS_T, HOURS_U, MINS_T, MINS_U, SECS_T, SECS_U, PM, ALARM};
   wire [23:0] dut_hms = {HOURS_T, HOURS_U, MINS_T, MINS_U, SECS_T, SECS_U};

   // Reference model: time as seconds of day, alarm as minutes of day.
   int   m_cnt = 0;
   logic m_tick = 1'b0;
   int   m_tod = 0;
   int   m_al = 0;
   logic m_alarm = 1'b0;
   logic m_pm = 1'b0, m_ph = 1'b0;
   logic m_prev_m = 1'b1, m_prev_h = 1'b1;

   always @(posedge CLK100MHZ or negedge RESET_BTN_N) begin
      if (!RESET_BTN_N) begin
         m_cnt = 0; m_tick = 1'b0; m_tod = 0; m_al = 0; m_alarm = 1'b0;
         m_pm = 1'b0; m_ph = 1'b0; m_prev_m = 1'b1; m_prev_h = 1'b1;
      end else begin
         automatic int   per = FAST ? TPS / FDV : TPS;
         automatic logic old_tick = m_tick;
         automatic logic hit = 1'b0;
         automatic logic em = INC_MIN & ~m_prev_m;
         automatic logic eh = INC_HOUR & ~m_prev_h;
         m_tick = (m_cnt >= per - 1);
         m_cnt  = m_tick ? 0 : m_cnt + 1;
         if (old_tick) begin
            m_tod = (m_tod + 1) % 86400;
            hit = (m_tod % 60 == 0) && (m_tod / 60 == m_al);
         end else begin
            if (m_pm) begin
               if (ALARM_SET) m_al = (m_al / 60) * 60 + (m_al % 60 + 1) % 60;
               else m_tod = (m_tod / 3600) * 3600 + (((m_tod / 60) % 60 + 1) % 60) * 60 + m_tod % 60;
            end
            if (m_ph) begin
               if (ALARM_SET) m_al = ((m_al / 60 + 1) % 24) * 60 + m_al % 60;
               else m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
            end
         end
         if (!ALARM_ARM || ALARM_ACK) m_alarm = 1'b0;
         else if (hit) m_alarm = 1'b1;
         m_pm = em | (m_pm & old_tick);
         m_ph = eh | (m_ph & old_tick);
         m_prev_m = INC_MIN;
         m_prev_h = INC_HOUR;
      end
   end

   function automatic logic [26:0] exp_vec();
      int hs, ms, s, hd;
      s  = m_tod % 60;
      hs = ALARM_SET ? m_al / 60 : m_tod / 3600;
      ms = ALARM_SET ? m_al % 60 : (m_tod / 60) % 60;
      hd = MODE_12H ? ((hs % 12 == 0) ? 12 : hs % 12) : hs;
      return {m_tick, 4'(hd / 10), 4'(hd % 10), 4'(ms / 10), 4'(ms % 10),
              4'(s / 10), 4'(s % 10), (hs >= 12), m_alarm};
   endfunction

   task automatic do_reset(input logic fast);
      @(negedge CLK100MHZ);
      RESET_BTN_N = 1'b0;
      {MODE_12H, INC_MIN, INC_HOUR, ALARM_SET, ALARM_ARM, ALARM_ACK} = '0;
      FAST = fast;
      @(negedge CLK100MHZ);
      RESET_BTN_N = 1'b1;
   endtask

   task automatic pulse_min(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK100MHZ); INC_MIN = 1'b1;
         @(negedge CLK100MHZ); INC_MIN = 1'b0;
      end
      repeat (2) @(negedge CLK100MHZ);
   endtask

   task automatic pulse_hour(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK100MHZ); INC_HOUR = 1'b1;
         @(negedge CLK100MHZ); INC_HOUR = 1'b0;
      end
      repeat (2) @(negedge CLK100MHZ);
   endtask

   task automatic test_reset();
      @(negedge CLK100MHZ);
      RESET_BTN_N = 1'b0; INC_MIN = 1'b1; INC_HOUR = 1'b1; FAST = 1'b0;
      @(negedge CLK100MHZ);
      checks++;
      if (dut_vec !== 27'd0) begin
         failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 27'd0);
      end
      RESET_BTN_N = 1'b1;
      repeat (4) @(negedge CLK100MHZ);
      checks++;
      if (dut_hms !== 24'h000000 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL held_button got=%h exp=%h", dut_vec, exp_vec());
      end
      INC_MIN = 1'b0; INC_HOUR = 1'b0;
   endtask

   task automatic test_prescaler();
      int first = -1, second = -1, nt = 0;
      do_reset(1'b0);
      for (int c = 1; c <= 25; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL presc_run c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
         if (SEC_TICK === 1'b1) begin
            if (first < 0) first = c; else if (second < 0) second = c;
         end
      end
      checks++;
      if (first != 10 || second != 20) begin
         failures++; $display("FAIL tick_timing got=%0d,%0d exp=10,20", first, second);
      end
      FAST = 1'b1;
      for (int c = 26; c <= 85; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL fast_run c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
         if (SEC_TICK === 1'b1) nt++;
      end
      checks++;
      if (nt != 12 || {SECS_T, SECS_U} !== 8'h14) begin
         failures++; $display("FAIL fast_ticks got=%0d/%h exp=12/14", nt, {SECS_T, SECS_U});
      end
   endtask

   task automatic test_rollover();
      logic found = 1'b0;
      do_reset(1'b0);
      pulse_hour(23);
      pulse_min(59);
      for (int c = 0; c < 800 && !found; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL roll_run got=%h exp=%h", dut_vec, exp_vec());
         end
         if (m_tick && m_tod == 86399) found = 1'b1;
      end
      checks++;
      if (!found || dut_hms !== 24'h235959) begin
         failures++; $display("FAIL roll_pre got=%h exp=235959", dut_hms);
      end
      @(negedge CLK100MHZ);
      checks++;
      if (dut_hms !== 24'h000000 || PM !== 1'b0) begin
         failures++; $display("FAIL roll_post got=%h pm=%b exp=000000 pm=0", dut_hms, PM);
      end
      INC_MIN = 1'b1;
      repeat (50) @(negedge CLK100MHZ);
      INC_MIN = 1'b0;
      repeat (2) @(negedge CLK100MHZ);
      checks++;
      if (dut_hms[23:8] !== 16'h0001 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL held_inc got=%h exp=0001xx", dut_hms);
      end
   endtask

   task automatic test_12h();
      do_reset(1'b0);
      MODE_12H = 1'b1;
      @(negedge CLK100MHZ);
      checks++;
      if ({HOURS_T, HOURS_U, PM} !== 9'h024) begin
         failures++; $display("FAIL h12_0 got=%h%h pm=%b exp=12 pm=0", HOURS_T, HOURS_U, PM);
      end
      pulse_hour(12);
      checks++;
      if ({HOURS_T, HOURS_U} !== 8'h12 || PM !== 1'b1) begin
         failures++; $display("FAIL h12_12 got=%h%h pm=%b exp=12 pm=1", HOURS_T, HOURS_U, PM);
      end
      pulse_hour(1);
      checks++;
      if ({HOURS_T, HOURS_U} !== 8'h01 || PM !== 1'b1) begin
         failures++; $display("FAIL h12_13 got=%h%h pm=%b exp=01 pm=1", HOURS_T, HOURS_U, PM);
      end
      MODE_12H = 1'b0;
      @(negedge CLK100MHZ);
      checks++;
      if ({HOURS_T, HOURS_U} !== 8'h13 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL h24_13 got=%h%h exp=13", HOURS_T, HOURS_U);
      end
   endtask

   task automatic test_tick_edit_collision();
      logic found = 1'b0;
      do_reset(1'b0);
      pulse_min(59);
      for (int c = 0; c < 800 && !found; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL coll_run got=%h exp=%h", dut_vec, exp_vec());
         end
         if (m_tick && m_tod == 3599) found = 1'b1;
      end
      checks++;
      if (!found || SEC_TICK !== 1'b1 || dut_hms !== 24'h005959) begin
         failures++; $display("FAIL coll_pre got=%h tick=%b exp=005959 tick=1", dut_hms, SEC_TICK);
      end
      INC_MIN = 1'b1;
      @(negedge CLK100MHZ);
      checks++;
      if (dut_hms !== 24'h010000) begin
         failures++; $display("FAIL coll_tick got=%h exp=010000", dut_hms);
      end
      @(negedge CLK100MHZ);
      checks++;
      if (dut_hms !== 24'h010100) begin
         failures++; $display("FAIL coll_edit got=%h exp=010100", dut_hms);
      end
      INC_MIN = 1'b0;
   endtask

   task automatic test_alarm();
      logic found = 1'b0;
      logic prev_tick = 1'b0;
      do_reset(1'b1);
      ALARM_SET = 1'b1;
      pulse_min(2);
      checks++;
      if (dut_hms[23:8] !== 16'h0002) begin
         failures++; $display("FAIL alarm_show got=%h exp=0002", dut_hms[23:8]);
      end
      ALARM_SET = 1'b0;
      @(negedge CLK100MHZ);
      checks++;
      if (dut_hms[23:8] !== 16'h0000 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL alarm_time got=%h exp=0000", dut_hms[23:8]);
      end
      ALARM_ARM = 1'b1;
      for (int c = 0; c < 800 && !found; c++) begin
         prev_tick = SEC_TICK;
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL alarm_run got=%h exp=%h", dut_vec, exp_vec());
         end
         if (ALARM === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || prev_tick !== 1'b1 || dut_hms !== 24'h000200) begin
         failures++; $display("FAIL alarm_rise got=%h prev_tick=%b exp=000200 prev_tick=1", dut_hms, prev_tick);
      end
      ALARM_ACK = 1'b1;
      @(negedge CLK100MHZ);
      ALARM_ACK = 1'b0;
      checks++;
      if (ALARM !== 1'b0) begin
         failures++; $display("FAIL alarm_ack got=%b exp=0", ALARM);
      end
      ALARM_ARM = 1'b0;
      pulse_min(59);
      found = 1'b0;
      for (int c = 0; c < 800 && !found; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL disarm_run got=%h exp=%h", dut_vec, exp_vec());
         end
         if (m_tod == 120) found = 1'b1;
      end
      checks++;
      if (!found || ALARM !== 1'b0 || dut_hms !== 24'h000200) begin
         failures++; $display("FAIL disarm got=%h alarm=%b exp=000200 alarm=0", dut_hms, ALARM);
      end
   endtask

   task automatic test_async_reset();
      logic found = 1'b0;
      do_reset(1'b1);
      ALARM_SET = 1'b1;
      pulse_hour(12);
      pulse_min(34);
      ALARM_SET = 1'b0;
      pulse_hour(12);
      pulse_min(33);
      ALARM_ARM = 1'b1;
      for (int c = 0; c < 1000 && !found; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL areset_run got=%h exp=%h", dut_vec, exp_vec());
         end
         if (m_tod == 12 * 3600 + 34 * 60 + 56) found = 1'b1;
      end
      checks++;
      if (!found || dut_hms !== 24'h123456 || ALARM !== 1'b1) begin
         failures++; $display("FAIL areset_pre got=%h alarm=%b exp=123456 alarm=1", dut_hms, ALARM);
      end
      #2 RESET_BTN_N = 1'b0;
      #1;
      checks++;
      if (dut_vec !== 27'd0 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL areset_now got=%h exp=%h", dut_vec, 27'd0);
      end
      @(negedge CLK100MHZ);
      ALARM_ARM = 1'b0;
      RESET_BTN_N = 1'b1;
   endtask

   task automatic test_random();
      do_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK100MHZ);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
         if ($urandom_range(3) == 0)  INC_MIN   = ~INC_MIN;
         if ($urandom_range(3) == 0)  INC_HOUR  = ~INC_HOUR;
         if ($urandom_range(15) == 0) MODE_12H  = ~MODE_12H;
         if ($urandom_range(15) == 0) ALARM_SET = ~ALARM_SET;
         if ($urandom_range(31) == 0) FAST      = ~FAST;
         if ($urandom_range(31) == 0) ALARM_ARM = ~ALARM_ARM;
         ALARM_ACK = ($urandom_range(15) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_rollover();
      test_12h();
      test_tick_edit_collision();
      test_alarm();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
